// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the segment-code path: blank codes, {A..G,DP} bit order, scan states.
package seven_seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam int SEG_A_BIT = 7;
  localparam int SEG_B_BIT = 6;
  localparam int SEG_C_BIT = 5;
  localparam int SEG_D_BIT = 4;
  localparam int SEG_E_BIT = 3;
  localparam int SEG_F_BIT = 2;
  localparam int SEG_G_BIT = 1;
  localparam int SEG_DP_BIT = 0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [6:0] seg_field(input logic [7:0] code);
    return code[SEG_A_BIT:SEG_G_BIT];
  endfunction

  function automatic logic dp_field(input logic [7:0] code);
    return code[SEG_DP_BIT];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Write port carrying one segment code into the scan driver's digit registers.
// wr_en acts as a valid with an always-ready consumer: every cycle with wr_en=1 is one accepted write.
interface seven_seg_scan_driver_if;
  logic       wr_en;
  logic [2:0] wr_digit;
  logic [7:0] wr_pattern;

  modport master (output wr_en, wr_digit, wr_pattern);
  modport slave  (input  wr_en, wr_digit, wr_pattern);
endinterface

// File: rtl/seven_seg_scan_driver_timer.sv
// Slot timer: counts cycles within a digit slot, steps the digit index, flags the frame wrap.
module seg_scan_timer
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int IW           = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          in_blank,
  output logic [IW-1:0] index,
  output logic          wrap,
  output scan_state_t   state
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLNK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0] cnt;

  // State tracks cnt: BLANK for the first BLANK_CYCLES of every slot, SHOW for the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      index <= '0;
      state <= ST_BLANK;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      state <= ST_BLANK;
      index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == BLNK_LAST) state <= ST_SHOW;
    end
  end

  assign in_blank = (state == ST_BLANK);
  assign wrap     = (cnt == CNT_LAST) && (index == IDX_LAST);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Common-anode scan driver: per-digit code registers, blanking gap, blink and registered pin outputs.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_LOG2   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_driver_if.slave wr,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output scan_state_t           dbg_state
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          in_blank;
  logic          wrap;
  logic [IW-1:0] index;

  seg_scan_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IW          (IW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .in_blank(in_blank),
    .index   (index),
    .wrap    (wrap),
    .state   (dbg_state)
  );

  logic [7:0] pattern [DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) pattern[i] <= SEG_BLANK;
    end else if (wr.wr_en && ({1'b0, wr.wr_digit} < 4'(DIGITS))) begin
      pattern[wr.wr_digit[IW-1:0]] <= wr.wr_pattern;
    end
  end

  // Blink phase flips each time the frame counter rolls over.
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (wrap) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (&frame_cnt) phase <= ~phase;
    end
  end

  logic              show;
  logic [7:0]        cur;
  logic [DIGITS-1:0] an_next;

  assign cur  = pattern[index];
  assign show = !in_blank && enable && !(phase && blink_mask[index]);

  always_comb begin
    an_next = '1;
    if (show) an_next[index] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= show ? seg_field(cur) : SEG_OFF;
      dp         <= show ? dp_field(cur) : 1'b1;
      an         <= an_next;
      frame_tick <= wrap;
    end
  end

endmodule
